uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, oversampled majority-vote bit sampling, optional even/odd parity.
// Latency: result pulses one cycle after the last tick of the stop bit (plus 2 cycles of input synchronizer).
// Backpressure: none; every frame produces exactly one pulse (data_valid, par_err or stp_err), nothing is queued.
// Ports:
//   i_clk, i_rst          - clock (one oversample tick per cycle), async active-high reset
//   i_rx_in               - asynchronous serial line, idle high
//   i_par_en, i_par_typ   - parity enable / type (0 even, 1 odd), captured at start detection
//   o_p_data              - last correctly received word, updated only with o_data_valid
//   o_data_valid          - one-cycle pulse, good frame
//   o_par_err, o_stp_err  - one-cycle pulses, parity mismatch / stop bit sampled 0 (stop error wins)
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_in,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic [DATA_WIDTH-1:0] o_p_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stp_err
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_meta_d;
  logic                    rx_s_q, rx_s_d;
  logic                    rx_prev_q, rx_prev_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [2:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    frm_par_err_q, frm_par_err_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;

  logic                    samp2;
  logic                    voted;
  logic                    bit_end;

  always_comb begin
    // With OVERSAMPLE=4 the third vote sample lands on the decision tick itself,
    // so it must come straight from the line rather than the sample register.
    samp2   = (tick_q == T_S2) ? rx_s_q : samp_q[2];
    voted   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp2) | (samp_q[1] & samp2);
    bit_end = (state_q != S_IDLE) && (tick_q == T_LAST);

    state_d       = state_q;
    rx_meta_d     = i_rx_in;
    rx_s_d        = rx_meta_q;
    rx_prev_d     = rx_s_q;
    tick_d        = tick_q;
    bit_cnt_d     = bit_cnt_q;
    samp_d        = samp_q;
    shift_d       = shift_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    frm_par_err_d = frm_par_err_q;
    p_data_d      = p_data_q;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;

    if (state_q != S_IDLE) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
      if (tick_q == T_S0) samp_d[0] = rx_s_q;
      if (tick_q == T_S1) samp_d[1] = rx_s_q;
      if (tick_q == T_S2) samp_d[2] = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        // rx_prev_q tracks the line every cycle, so a line stuck low after a
        // stop error cannot retrigger until it has been seen high again.
        if (rx_prev_q && !rx_s_q) begin
          state_d       = S_START;
          tick_d        = TW'(1);  // detection cycle is tick 0 of the start bit
          bit_cnt_d     = '0;
          par_en_d      = i_par_en;
          par_typ_d     = i_par_typ;
          frm_par_err_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_d = voted ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {voted, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == B_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          if (voted != ((^shift_q) ^ par_typ_q)) frm_par_err_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          if (!voted) begin
            stp_err_d = 1'b1;
          end else if (frm_par_err_q) begin
            par_err_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      tick_q        <= '0;
      bit_cnt_q     <= '0;
      samp_q        <= '0;
      shift_q       <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      frm_par_err_q <= 1'b0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      tick_q        <= tick_d;
      bit_cnt_q     <= bit_cnt_d;
      samp_q        <= samp_d;
      shift_q       <= shift_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      frm_par_err_q <= frm_par_err_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
    end
  end

  assign o_p_data     = p_data_q;
  assign o_data_valid = data_valid_q;
  assign o_par_err    = par_err_q;
  assign o_stp_err    = stp_err_q;

endmodule
